// File: rtl/led_strip_streamer.sv
// WS2812-class strip serialiser: fetches per-LED colour words over a req/valid port and
// emits them MSB-first with programmable bit timing. Optional dimming: LED_STRIP_BRIGHTNESS_EN.
module led_strip_streamer #(
  parameter int NUM_LEDS     = 400,
  parameter int BITS_PER_LED = 24,
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int T_BIT        = 63,
  parameter int T_RESET      = 3000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        refresh,
  input  logic                        refresh_lock,
  output logic [$clog2(NUM_LEDS)-1:0] pix_addr,
  output logic                        pix_req,
  input  logic                        pix_valid,
  input  logic [BITS_PER_LED-1:0]     pix_data,
`ifdef LED_STRIP_BRIGHTNESS_EN
  input  logic [7:0]                  brightness,
`endif
  output logic                        busy,
  output logic                        frame_done,
  output logic                        underrun,
  output logic                        led_out
);

  localparam int AW  = $clog2(NUM_LEDS);
  localparam int BCW = $clog2(T_BIT);
  localparam int LCW = $clog2(T_RESET + 1);
  localparam int IW  = $clog2(BITS_PER_LED);

  localparam logic [BCW-1:0] BIT_LAST   = BCW'(T_BIT - 1);
  localparam logic [BCW-1:0] T0H_C      = BCW'(T0H);
  localparam logic [BCW-1:0] T1H_C      = BCW'(T1H);
  localparam logic [LCW-1:0] LATCH_LAST = LCW'(T_RESET - 1);
  localparam logic [AW-1:0]  LAST_LED   = AW'(NUM_LEDS - 1);
  localparam logic [IW-1:0]  LAST_BIT   = IW'(BITS_PER_LED - 1);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, STALL, LATCH} state_e;

  state_e                  state_q, state_d;
  logic                    pending_q, pending_d;
  logic                    boot_q, boot_d;
  logic [AW-1:0]           pix_addr_q, pix_addr_d;
  logic                    pix_req_q, pix_req_d;
  logic [AW-1:0]           cur_q, cur_d;
  logic [BITS_PER_LED-1:0] shreg_q, shreg_d;
  logic [IW-1:0]           bit_idx_q, bit_idx_d;
  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [LCW-1:0]          latch_cnt_q, latch_cnt_d;
  logic [BITS_PER_LED-1:0] hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic                    underrun_q, underrun_d;
  logic                    frame_done_q, frame_done_d;
  logic                    led_q, led_d;

  logic                    accept;
  logic                    start_pixel;
  logic [BITS_PER_LED-1:0] start_word;
  logic [BITS_PER_LED-1:0] word_in;
  logic [BCW-1:0]          thigh;

`ifdef LED_STRIP_BRIGHTNESS_EN
  // Each 8-bit channel is scaled by (brightness+1)/256, so 255 is an exact pass-through.
  function automatic logic [BITS_PER_LED-1:0] dim(input logic [BITS_PER_LED-1:0] w,
                                                 input logic [7:0] b);
    logic [15:0] prod;
    dim = '0;
    for (int c = 0; c < BITS_PER_LED / 8; c++) begin
      prod = 16'(w[c*8 +: 8]) * (16'(b) + 16'd1);
      dim[c*8 +: 8] = prod[15:8];
    end
  endfunction

  assign word_in = dim(pix_data, brightness);
`else
  assign word_in = pix_data;
`endif

  assign accept = pix_req_q & pix_valid;
  assign thigh  = shreg_q[BITS_PER_LED-1] ? T1H_C : T0H_C;

  // Out of reset the block sits in LATCH so the strip always sees a full latch gap first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LATCH;
      pending_q    <= 1'b0;
      boot_q       <= 1'b1;
      pix_addr_q   <= '0;
      pix_req_q    <= 1'b0;
      cur_q        <= '0;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      bit_cnt_q    <= '0;
      latch_cnt_q  <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
      led_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      boot_q       <= boot_d;
      pix_addr_q   <= pix_addr_d;
      pix_req_q    <= pix_req_d;
      cur_q        <= cur_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      bit_cnt_q    <= bit_cnt_d;
      latch_cnt_q  <= latch_cnt_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_done_d;
      led_q        <= led_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | refresh;
    boot_d       = boot_q;
    pix_addr_d   = pix_addr_q;
    pix_req_d    = pix_req_q & ~pix_valid;
    cur_d        = cur_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    bit_cnt_d    = bit_cnt_q;
    latch_cnt_d  = latch_cnt_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    underrun_d   = underrun_q;
    frame_done_d = 1'b0;
    led_d        = 1'b0;
    start_pixel  = 1'b0;
    start_word   = '0;

    unique case (state_q)
      IDLE: begin
        if (pending_q && !refresh_lock) begin
          state_d    = FETCH;
          pending_d  = refresh;
          underrun_d = 1'b0;
          pix_addr_d = '0;
          pix_req_d  = 1'b1;
        end
      end
      FETCH: begin
        if (accept) begin
          start_pixel = 1'b1;
          start_word  = word_in;
          cur_d       = '0;
        end
      end
      SHIFT: begin
        if (accept) begin
          hold_d      = word_in;
          hold_full_d = 1'b1;
        end
        if (bit_cnt_q != BIT_LAST) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          led_d     = (bit_cnt_d < thigh);
        end else if (bit_idx_q != LAST_BIT) begin
          shreg_d   = shreg_q << 1;
          bit_idx_d = bit_idx_q + 1'b1;
          bit_cnt_d = '0;
          led_d     = 1'b1;
        end else if (cur_q == LAST_LED) begin
          state_d     = LATCH;
          latch_cnt_d = '0;
        end else if (hold_full_q || accept) begin
          // A word arriving exactly on the pixel boundary is used directly, without a stall.
          start_pixel = 1'b1;
          start_word  = hold_full_q ? hold_q : word_in;
          hold_full_d = 1'b0;
          cur_d       = cur_q + 1'b1;
        end else begin
          state_d    = STALL;
          underrun_d = 1'b1;
        end
      end
      STALL: begin
        if (accept) begin
          start_pixel = 1'b1;
          start_word  = word_in;
          cur_d       = cur_q + 1'b1;
        end
      end
      LATCH: begin
        if (latch_cnt_q == LATCH_LAST) begin
          state_d      = IDLE;
          frame_done_d = ~boot_q;
          boot_d       = 1'b0;
        end else begin
          latch_cnt_d = latch_cnt_q + 1'b1;
        end
      end
      default: state_d = LATCH;
    endcase

    // Loading a pixel opens its first bit period and prefetches the next word.
    if (start_pixel) begin
      state_d   = SHIFT;
      shreg_d   = start_word;
      bit_idx_d = '0;
      bit_cnt_d = '0;
      led_d     = 1'b1;
      if (cur_d != LAST_LED) begin
        pix_addr_d = cur_d + 1'b1;
        pix_req_d  = 1'b1;
      end
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  assign pix_addr   = pix_addr_q;
  assign pix_req    = pix_req_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  assign led_out    = led_q;

endmodule

// File: tb/tb_led_strip_streamer.sv
// Self-checking bench for led_strip_streamer: a start-up vector table, hand-written
// corner-case frames and random frames checked against a pulse-level strip model.
module tb_led_strip_streamer;

  localparam int NL  = 3;
  localparam int BPL = 8;
  localparam int TOH = 2;
  localparam int TIH = 4;
  localparam int TB  = 6;
  localparam int TR  = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       refresh = 1'b0;
  logic       refresh_lock = 1'b0;
  logic [1:0] pix_addr;
  logic       pix_req;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       busy;
  logic       frame_done;
  logic       underrun;
  logic       led_out;
`ifdef LED_STRIP_BRIGHTNESS_EN
  logic [7:0] brightness = 8'd255;
`endif

  led_strip_streamer #(
    .NUM_LEDS(NL), .BITS_PER_LED(BPL), .T0H(TOH), .T1H(TIH), .T_BIT(TB), .T_RESET(TR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .refresh(refresh),
    .refresh_lock(refresh_lock),
    .pix_addr(pix_addr),
    .pix_req(pix_req),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
`ifdef LED_STRIP_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .busy(busy),
    .frame_done(frame_done),
    .underrun(underrun),
    .led_out(led_out)
  );

  always #5 clk = ~clk;

  // Frame buffer: each word is granted memDelay cycles after its request first appears.
  logic [7:0] memData [NL];
  int         memDelay [NL];
  int         reqCycles = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) reqCycles <= 0;
    else if (pix_req && !pix_valid) reqCycles <= reqCycles + 1;
    else reqCycles <= 0;
  end

  assign pix_valid = pix_req && (reqCycles >= memDelay[pix_addr]);
  assign pix_data  = memData[pix_addr];

  // Line monitor: records high-pulse lengths, rise times and frame_done pulses.
  int   cyc = 0;
  int   runHigh = 0;
  int   doneCount = 0;
  int   lastDoneCyc = 0;
  logic prevLed = 1'b0;
  int   highRuns[$];
  int   riseCyc[$];

  always @(negedge clk) begin
    cyc++;
    if (led_out === 1'b1) begin
      if (!prevLed) riseCyc.push_back(cyc);
      runHigh++;
      prevLed = 1'b1;
    end else begin
      if (prevLed) begin
        highRuns.push_back(runHigh);
        runHigh = 0;
      end
      prevLed = 1'b0;
    end
    if (frame_done === 1'b1) begin
      doneCount++;
      lastDoneCyc = cyc;
    end
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       refresh;
    logic       lock;
    logic       expBusy;
    logic       expReq;
    logic [1:0] expAddr;
    logic       expLed;
    logic       expDone;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic l);
    refresh      = r;
    refresh_lock = l;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int expWord(input int p);
`ifdef LED_STRIP_BRIGHTNESS_EN
    return (int'(memData[p]) * (int'(brightness) + 1)) / 256;
`else
    return int'(memData[p]);
`endif
  endfunction

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic waitDone(input int d0, input int limit, input string tag);
    int n = 0;
    while (doneCount == d0 && n < limit) begin
      tick();
      n++;
    end
    checkOutput({tag, " frame_done count"}, doneCount - d0, 1);
  endtask

  // Expected line behaviour derived from words, bit timing and memory latency.
  task automatic verifyFrame(input int hs, input int rs, input string tag);
    int nHigh;
    int nRise;
    int k;
    int w;
    int expUnder;
    nHigh = highRuns.size() - hs;
    nRise = riseCyc.size() - rs;
    checkOutput({tag, " pulse count"}, nHigh, NL * BPL);
    if (nHigh >= NL * BPL && nRise >= NL * BPL) begin
      for (int p = 0; p < NL; p++) begin
        w = expWord(p);
        for (int b = 0; b < BPL; b++) begin
          k = p * BPL + b;
          checkOutput($sformatf("%s high p%0d b%0d", tag, p, b), highRuns[hs + k],
                      w[BPL-1-b] ? TIH : TOH);
          if (k > 0)
            checkOutput($sformatf("%s spacing p%0d b%0d", tag, p, b),
                        riseCyc[rs + k] - riseCyc[rs + k - 1],
                        (b == 0) ? maxi(BPL * TB, memDelay[p] + 1) - (BPL - 1) * TB : TB);
        end
      end
      checkOutput({tag, " latch gap"}, lastDoneCyc - riseCyc[rs + NL * BPL - 1], TB + TR);
    end
    expUnder = 0;
    for (int p = 1; p < NL; p++)
      if (memDelay[p] + 1 > BPL * TB) expUnder = 1;
    checkOutput({tag, " underrun"}, int'(underrun), expUnder);
  endtask

  task automatic runFrame(input string tag);
    int hs;
    int rs;
    int d0;
    hs = highRuns.size();
    rs = riseCyc.size();
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    waitDone(d0, 2000, tag);
    verifyFrame(hs, rs, tag);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hs;
    int rs;
    int d0;
    int firstIdle;
    int ledSeen;
    int n;

    for (int i = 0; i < 16; i++) vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0};

    memData[0] = 8'hA5; memData[1] = 8'h00; memData[2] = 8'hFF;
    for (int p = 0; p < NL; p++) memDelay[p] = 0;

    tick();
    tick();
    checkOutput("reset led_out", int'(led_out), 0);
    checkOutput("reset pix_req", int'(pix_req), 0);
    checkOutput("reset pix_addr", int'(pix_addr), 0);
    checkOutput("reset frame_done", int'(frame_done), 0);
    checkOutput("reset underrun", int'(underrun), 0);
    checkOutput("reset busy", int'(busy), 1);

    // Boot latch gap, locked refresh, then start of the A5/00/FF frame.
    hs = highRuns.size();
    rs = riseCyc.size();
    d0 = doneCount;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].refresh, vecs[i].lock);
      tick();
      checkOutput($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d pix_req", i), int'(pix_req), int'(vecs[i].expReq));
      checkOutput($sformatf("vec%0d pix_addr", i), int'(pix_addr), int'(vecs[i].expAddr));
      checkOutput($sformatf("vec%0d led_out", i), int'(led_out), int'(vecs[i].expLed));
      checkOutput($sformatf("vec%0d frame_done", i), int'(frame_done), int'(vecs[i].expDone));
    end
    applyStimulus(1'b0, 1'b0);
    waitDone(d0, 2000, "frameA");
    verifyFrame(hs, rs, "frameA");

    // Late pixel 2 forces a stall between pixels 1 and 2.
    memDelay[2] = 60;
    runFrame("stall");
    memDelay[2] = 0;

    // Start latency, underrun clear, and refresh queued while busy.
    hs = highRuns.size();
    rs = riseCyc.size();
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("latency k underrun still set", int'(underrun), 1);
    checkOutput("latency k busy", int'(busy), 0);
    tick();
    checkOutput("latency k+1 busy", int'(busy), 1);
    checkOutput("latency k+1 underrun cleared", int'(underrun), 0);
    checkOutput("latency k+1 led_out", int'(led_out), 0);
    tick();
    checkOutput("latency k+2 led_out", int'(led_out), 1);
    for (int i = 0; i < 30; i++) tick();
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    waitDone(d0, 2000, "queuedA");
    verifyFrame(hs, rs, "queuedA");
    checkOutput("queued done busy", int'(busy), 0);
    hs = highRuns.size();
    rs = riseCyc.size();
    d0 = doneCount;
    tick();
    checkOutput("queued restart busy", int'(busy), 1);
    checkOutput("queued restart pix_req", int'(pix_req), 1);
    waitDone(d0, 2000, "queuedB");
    verifyFrame(hs, rs, "queuedB");

    // Reset while the line is high; a pending refresh must be dropped.
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    n = 0;
    while (led_out !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    for (int i = 0; i < 3; i++) tick();
    n = 0;
    while (led_out !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("pre-reset led_out high", int'(led_out), 1);
    applyStimulus(1'b1, 1'b0);
    #1;
    applyStimulus(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset led_out", int'(led_out), 0);
    checkOutput("async reset pix_req", int'(pix_req), 0);
    checkOutput("async reset busy", int'(busy), 1);
    tick();
    rst_n = 1'b1;
    d0 = doneCount;
    firstIdle = -1;
    ledSeen = 0;
    for (int i = 1; i <= TR + 6; i++) begin
      tick();
      if (busy === 1'b0 && firstIdle < 0) firstIdle = i;
      if (led_out !== 1'b0) ledSeen = 1;
    end
    checkOutput("post-reset gap length", firstIdle, TR);
    checkOutput("post-reset led_out quiet", ledSeen, 0);
    checkOutput("post-reset no frame_done", doneCount - d0, 0);
    checkOutput("post-reset pending dropped", int'(busy), 0);
    runFrame("after-reset");

`ifdef LED_STRIP_BRIGHTNESS_EN
    memData[0] = 8'hFF; memData[1] = 8'hFF; memData[2] = 8'hFF;
    brightness = 8'd127;
    runFrame("bright127");
    brightness = 8'd0;
    runFrame("bright0");
    brightness = 8'd255;
`endif

    // Random words and memory latencies, including both sides of the pixel boundary.
    for (int f = 0; f < 8; f++) begin
      for (int p = 0; p < NL; p++) memData[p] = 8'($urandom);
      memDelay[0] = $urandom_range(0, 3);
      for (int p = 1; p < NL; p++) begin
        case ($urandom_range(0, 4))
          0: memDelay[p] = 0;
          1: memDelay[p] = $urandom_range(1, 10);
          2: memDelay[p] = BPL * TB - 1;
          3: memDelay[p] = BPL * TB;
          default: memDelay[p] = 70;
        endcase
      end
      if (f == 0) memDelay[1] = BPL * TB - 1;
      if (f == 1) memDelay[1] = BPL * TB;
`ifdef LED_STRIP_BRIGHTNESS_EN
      brightness = 8'($urandom);
`endif
      runFrame($sformatf("rand%0d", f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_strip_streamer.md
# led_strip_streamer

Parametrised serial driver for WS2812-class LED strips, the next-generation successor to the fixed-colour LED controller. Per-LED colour words are fetched on demand from an external frame buffer through a request/valid read port, so there is no wide array input. Each word is serialised MSB-first with configurable bit timing, and every frame ends with a latch gap. The block sits between the frame-composition logic (cell/display decoders writing the buffer) and the strip's data pin.

## Interface
- `NUM_LEDS`, default 400: LEDs per frame.
- `BITS_PER_LED`, default 24: colour word width. Must be a multiple of 8.
- `T0H`, default 20: high time of a '0' bit, in clk cycles.
- `T1H`, default 40: high time of a '1' bit, in clk cycles.
- `T_BIT`, default 63: bit period, in clk cycles. Requires `T0H < T1H < T_BIT`.
- `T_RESET`, default 3000: latch gap, in clk cycles, during which the line is held low.
- `clk`, in, 1: sole clock; all logic on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `refresh`, in, 1: frame request pulse; remembered until served.
- `refresh_lock`, in, 1: while high, no new frame starts.
- `pix_addr`, out, `$clog2(NUM_LEDS)`: LED index being fetched.
- `pix_req`, out, 1: fetch request; held high until accepted.
- `pix_valid`, in, 1: `pix_data` is valid for `pix_addr`. A same-cycle response is allowed.
- `pix_data`, in, `BITS_PER_LED`: colour word, MSB transmitted first.
- `brightness`, in, 8: global dimming. Present only with `LED_STRIP_BRIGHTNESS_EN`.
- `busy`, out, 1: high outside IDLE.
- `frame_done`, out, 1: one-cycle pulse at the end of LATCH.
- `underrun`, out, 1: sticky; cleared at frame start.
- `led_out`, out, 1: strip data line (registered).

## Operation
- States:
  - IDLE
  - FETCH: first pixel of a frame.
  - SHIFT: bit emission plus prefetch.
  - STALL: waiting for a late pixel.
  - LATCH: `T_RESET` low cycles.
- Refresh handling:
  - A `refresh` pulse sets `pending`.
  - IDLE moves to FETCH when `pending && !refresh_lock`. On that transition: clear `pending` and `underrun`, set `pix_addr`=0.
  - FETCH holds `pix_req`=1. An edge with `pix_valid`=1 loads the shift register and enters SHIFT.
- SHIFT:
  - At the start of each bit period, `led_out`=1.
  - `led_out` drops after `T0H` or `T1H` cycles, by the current bit.
  - The period lasts exactly `T_BIT` cycles.
- Prefetch: when the first bit of pixel i starts and i < `NUM_LEDS`−1, set `pix_addr`=i+1 and `pix_req`=1. The accepted word goes to a holding register.
- End of the last bit of pixel i:
  - Holding register full: load it; the next bit period starts immediately, with no gap.
  - Holding register empty: enter STALL (`led_out`=0, `underrun`=1). Resume SHIFT on the cycle after acceptance.
  - Last pixel: enter LATCH.
- LATCH: `led_out`=0 for `T_RESET` cycles, then pulse `frame_done` and return to IDLE.
- `refresh` arriving while busy sets `pending`; that frame starts right after IDLE is re-entered (if unlocked).
- `refresh_lock` gates only the IDLE→FETCH decision. A frame in progress always completes.
- After reset deassertion the block enters LATCH first (`busy`=1). This guarantees a clean latch gap before the first frame. No `frame_done` pulse is issued for this gap.

## Timing
- Reset values:
  - `led_out`=0, `pix_req`=0, `pix_addr`=0, `frame_done`=0, `underrun`=0.
  - `busy`=1 (state LATCH, counter 0), `pending`=0.
- Reset mid-frame: `led_out` goes low immediately (asynchronous). Any fetch is abandoned, `pending` is lost, and the block restarts with the LATCH gap.
- Start latency, with `pix_valid` tied high and IDLE unlocked: edge k samples `refresh` → edge k+1 enters FETCH → edge k+2 sets `led_out`=1.
- Frame length without stalls: `NUM_LEDS`×`BITS_PER_LED`×`T_BIT` cycles of SHIFT, then `T_RESET` cycles of LATCH.
- `pix_req` stays high across cycles until the edge where `pix_valid`=1. It deasserts on the following cycle unless a new request starts.
- `pix_valid` while `pix_req`=0 is ignored.
- Counter widths: bit counter `$clog2(T_BIT)`, latch counter `$clog2(T_RESET+1)`. Neither wraps: each is reloaded at every period start.

## Configuration
- `LED_STRIP_BRIGHTNESS_EN` defined:
  - The `brightness` port exists.
  - Each 8-bit channel c of the accepted word is replaced by `(c × (brightness+1)) >> 8` when it is loaded.
  - Result: 255 passes the word unchanged; 0 yields all-zero.
  - `brightness` is sampled at acceptance time, per pixel.
- Undefined: the port is absent and `pix_data` is transmitted unmodified.

## Test plan
Common parameters: `NUM_LEDS`=3, `BITS_PER_LED`=8, `T0H`=2, `T1H`=4, `T_BIT`=6, `T_RESET`=10.
- Reset release, `refresh` held 0 → `busy` stays 1 for 10 cycles, then 0; `led_out` stays 0; no `frame_done` pulse.
- `refresh` pulse, zero-latency memory returning 8'hA5, 8'h00, 8'hFF → `led_out` rises 2 edges after the sample. The 24 bit periods have high times 4,2,4,2,2,4,2,4, then eight of 2, then eight of 4. This is followed by 10 low cycles, one `frame_done` pulse, and `underrun`=0.
- Memory delays pixel 2 by 60 cycles → line low between pixel 1 and pixel 2, `underrun`=1. The correct pixel 2 waveform follows, and `underrun` is cleared on the next frame start.
- `refresh_lock`=1 with a `refresh` pulse → no `pix_req`. Releasing the lock after 50 cycles starts the frame within 2 edges.
- `refresh` during SHIFT → the current frame finishes, then a second frame starts right after `frame_done`.
- With `LED_STRIP_BRIGHTNESS_EN`, `brightness`=127, pixel 8'hFF → transmitted 8'h7F. `brightness`=0 → 8'h00.
- `rst_n` pulled low mid-SHIFT → `led_out` goes 0 asynchronously. After release: 10-cycle LATCH, then a new `refresh` is served normally.
